debounce_bank: RTL and testbench
================================

# debounce_bank

Multi-channel, parametrised debouncer for the board's push-button and switch inputs. Each channel synchronises one raw input, waits until it has been stable for a programmable number of cycles, and then publishes a clean level plus single-cycle press and release pulses. It sits between the top-level pins and the game-control logic. Compile-time options add per-channel input inversion and hold/auto-repeat pulses.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent input channels; must be 1 or more.
- `DELAY_COUNTS`, 2500: stable cycles required before the level changes (50 µs at 50 MHz); must be 1 or more.
- `INVERT`, `{CHANNELS{1'b0}}`: per-channel mask. Bit = 1 inverts that raw input before synchronisation, for active-low buttons.
- `HOLD_COUNTS`, 50_000_000: cycles of continuous high level before the first `held` pulse. Used only with `DEBOUNCE_HOLD_EN`.
- `REPEAT_COUNTS`, 10_000_000: cycles between subsequent `held` pulses. Used only with `DEBOUNCE_HOLD_EN`.

Ports:
- `clk`, input, 1: the single clock. All state is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `button`, input, CHANNELS: raw asynchronous inputs.
- `level`, output, CHANNELS: debounced level, registered.
- `pressed`, output, CHANNELS: one-cycle pulse when `level` goes 0→1.
- `released`, output, CHANNELS: one-cycle pulse when `level` goes 1→0.
- `held`, output, CHANNELS: hold/auto-repeat pulse. Present only with `DEBOUNCE_HOLD_EN`.

## Operation
All channels are identical and independent. Per channel, with `x = button[i] ^ INVERT[i]`:
- **Synchroniser:** two flops, s1 then s2; s2 is the synchronised input.
- **prev:** takes s2 whenever s2 differs from prev.
- **count:**
  - cleared to 0 when s2 differs from prev;
  - otherwise increments, saturating at DELAY_COUNTS;
  - width is `$clog2(DELAY_COUNTS+1)`.
- **Level update:** when s2 equals prev, count equals DELAY_COUNTS and level differs from prev, then on the same edge:
  - level takes prev;
  - `pressed` is set if the new level is 1, otherwise `released` is set.
  - In every other cycle `pressed` and `released` are 0.
- **Glitch rejection:** any excursion on s2 shorter than DELAY_COUNTS+1 cycles leaves level unchanged and produces no pulse.
- **`pressed` and `released`:** never asserted in the same cycle on the same channel. Several channels may pulse in the same cycle.
- **Reset:**
  - Asynchronous. All flops clear to 0: s1, s2, prev, count, level, pressed, released, and the hold state.
  - Reset asserted mid-count discards the pending change.
  - An input already high when reset is released is reported as a normal press after the full latency.

## Timing
- If x changes before edge k and then stays stable:
  - s2 changes at edge k+1;
  - prev updates and count clears at edge k+2;
  - count reaches DELAY_COUNTS at edge k+2+DELAY_COUNTS;
  - level and the pulse update at edge k+3+DELAY_COUNTS.
- Latency is therefore DELAY_COUNTS+3 edges after the first sampling edge.
- Each pulse is exactly one clock wide.
- No combinational path from `button` to any output.
- Reset values: every output is 0.

## Configuration
Macro `DEBOUNCE_HOLD_EN`.

When defined:
- Each channel gets a hold counter, width `$clog2(max(HOLD_COUNTS,REPEAT_COUNTS)+1)`, and the `held` port exists.
- The counter clears while level is 0 and on the cycle `pressed` fires.
- While level is 1 it increments. Reaching HOLD_COUNTS raises `held` for one cycle, and the counter then reloads so that further pulses follow every REPEAT_COUNTS cycles.
- A release stops repeats immediately. No `held` pulse is produced in the same cycle as `released`.

When undefined:
- No hold logic and no `held` port.
- All other behaviour is identical.

## Structure
- **Package `debounce_pkg`:**
  - function `cnt_width(n)` returning `$clog2(n+1)`;
  - default constants `DEFAULT_DELAY_COUNTS`, `DEFAULT_HOLD_COUNTS` and `DEFAULT_REPEAT_COUNTS`.
- **Sub-module `debounce_channel`:**
  - one channel: synchroniser, prev, count, level, pulses, and the optional hold logic;
  - `debounce_bank` instantiates it CHANNELS times with a generate loop.

## Test plan
Bench parameters: CHANNELS=4, DELAY_COUNTS=8, HOLD_COUNTS=40, REPEAT_COUNTS=16, INVERT=4'b1000.

- **Clean press:** ch0 raised and held → `level[0]` goes to 1 at edge 11 after the first sampling edge; `pressed[0]` high for exactly 1 cycle; `released` stays 0.
- **Bounce:** ch1 toggled with high/low intervals of 3, 5 and 2 cycles, then held high → no pulse during bouncing; `pressed[1]` exactly once, 11 edges after the final transition.
- **Short glitch:** ch2 high for 8 cycles, then low → `level[2]` stays 0; no pulses at all.
- **Inversion and reset release:** ch3 raw input held low (pressed, because `INVERT[3]`) across deassertion of `rst_n` → `pressed[3]` 11 edges after the first edge following reset release.
- **Reset mid-count:** `rst_n` asserted 5 cycles into ch0's stable window → all outputs 0 immediately, without waiting for a clock edge; the count restarts after release.
- **Hold (with `DEBOUNCE_HOLD_EN`):** ch0 held high → `held[0]` 40 cycles after `pressed[0]`, then every 16 cycles; release → no further `held`.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, types and helpers for the debounce bank.
// Optional hold/auto-repeat logic elsewhere is enabled by the DEBOUNCE_HOLD_EN macro.
package debounce_pkg;

  localparam int unsigned DEFAULT_DELAY_COUNTS  = 2500;
  localparam int unsigned DEFAULT_HOLD_COUNTS   = 50_000_000;
  localparam int unsigned DEFAULT_REPEAT_COUNTS = 10_000_000;

  // Hold counter phase: waiting for the first held pulse, or auto-repeating.
  typedef enum logic {
    HoldFirst,
    HoldRepeat
  } hold_phase_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge pulses.
// With DEBOUNCE_HOLD_EN defined, also a hold/auto-repeat pulse generator.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DELAY_COUNTS  = DEFAULT_DELAY_COUNTS,
  parameter bit          INVERT        = 1'b0
`ifdef DEBOUNCE_HOLD_EN
  ,
  parameter int unsigned HOLD_COUNTS   = DEFAULT_HOLD_COUNTS,
  parameter int unsigned REPEAT_COUNTS = DEFAULT_REPEAT_COUNTS
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
`ifdef DEBOUNCE_HOLD_EN
  output logic o_held,
`endif
  output logic o_level,
  output logic o_pressed,
  output logic o_released
);

  localparam int unsigned CntW = cnt_width(DELAY_COUNTS);
  localparam logic [CntW-1:0] CntMax = CntW'(DELAY_COUNTS);

  logic            r_s1;
  logic            r_s2;
  logic            r_prev;
  logic            r_level;
  logic            r_pressed;
  logic            r_released;
  logic [CntW-1:0] r_count;

  logic w_x;
  logic w_changed;
  logic w_update;

  assign w_x       = i_button ^ INVERT;
  assign w_changed = (r_s2 != r_prev);
  // Commit only once prev has been stable for the full window and disagrees with level.
  assign w_update  = !w_changed && (r_count == CntMax) && (r_level != r_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_prev     <= 1'b0;
      r_count    <= '0;
      r_level    <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_s1 <= w_x;
      r_s2 <= r_s1;
      if (w_changed) begin
        r_prev  <= r_s2;
        r_count <= '0;
      end else if (r_count != CntMax) begin
        r_count <= r_count + CntW'(1);
      end
      if (w_update) begin
        r_level <= r_prev;
      end
      r_pressed  <= w_update && r_prev;
      r_released <= w_update && !r_prev;
    end
  end

  assign o_level    = r_level;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned HoldW = cnt_width(max_u(HOLD_COUNTS, REPEAT_COUNTS));

  logic [HoldW-1:0] r_hold_cnt;
  hold_phase_e      r_phase;
  logic             r_held;
  logic [HoldW-1:0] w_hold_inc;
  logic [HoldW-1:0] w_hold_target;

  assign w_hold_inc    = r_hold_cnt + HoldW'(1);
  assign w_hold_target = (r_phase == HoldRepeat) ? HoldW'(REPEAT_COUNTS) : HoldW'(HOLD_COUNTS);

  // Any level change (press or release edge) restarts the hold sequence and
  // suppresses held, so a release never coincides with a repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_phase    <= HoldFirst;
      r_held     <= 1'b0;
    end else if (!r_level || w_update) begin
      r_hold_cnt <= '0;
      r_phase    <= HoldFirst;
      r_held     <= 1'b0;
    end else if (w_hold_inc == w_hold_target) begin
      r_hold_cnt <= '0;
      r_phase    <= HoldRepeat;
      r_held     <= 1'b1;
    end else begin
      r_hold_cnt <= w_hold_inc;
      r_held     <= 1'b0;
    end
  end

  assign o_held = r_held;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of CHANNELS independent debouncers with level, press and release outputs.
// Defining DEBOUNCE_HOLD_EN adds the held port and per-channel hold/auto-repeat logic.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned          CHANNELS      = 4,
  parameter int unsigned          DELAY_COUNTS  = DEFAULT_DELAY_COUNTS,
  parameter logic [CHANNELS-1:0]  INVERT        = {CHANNELS{1'b0}},
  parameter int unsigned          HOLD_COUNTS   = DEFAULT_HOLD_COUNTS,
  parameter int unsigned          REPEAT_COUNTS = DEFAULT_REPEAT_COUNTS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
`ifdef DEBOUNCE_HOLD_EN
  output logic [CHANNELS-1:0] held,
`endif
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released
);

  // Zero-length windows are meaningless; such a configuration builds a silent bank.
  localparam bit ParamsOk = (CHANNELS >= 1) && (DELAY_COUNTS >= 1) &&
                            (HOLD_COUNTS >= 1) && (REPEAT_COUNTS >= 1);

  if (ParamsOk) begin : g_bank
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
        .DELAY_COUNTS  (DELAY_COUNTS),
        .INVERT        (INVERT[i])
`ifdef DEBOUNCE_HOLD_EN
        ,
        .HOLD_COUNTS   (HOLD_COUNTS),
        .REPEAT_COUNTS (REPEAT_COUNTS)
`endif
      ) u_channel (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_button   (button[i]),
`ifdef DEBOUNCE_HOLD_EN
        .o_held     (held[i]),
`endif
        .o_level    (level[i]),
        .o_pressed  (pressed[i]),
        .o_released (released[i])
      );
    end
  end else begin : g_invalid
    logic [CHANNELS-1:0] w_unused;
    assign w_unused = button ^ {CHANNELS{clk ^ rst_n}};
`ifdef DEBOUNCE_HOLD_EN
    assign held     = '0;
`endif
    assign level    = '0;
    assign pressed  = '0;
    assign released = '0;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: expected pulses are queued as stimulus is driven
// and matched against the DUT outputs every cycle by a monitor.
module tb_debounce_bank;

  localparam int Delay = 8;
  // Input driven on a falling edge shows its pulse on the falling edge Delay+4 edges later.
  localparam int Lat   = Delay + 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] button;
  logic [3:0] level;
  logic [3:0] pressed;
  logic [3:0] released;
`ifdef DEBOUNCE_HOLD_EN
  logic [3:0] held;
  localparam int NKinds = 3;
`else
  localparam int NKinds = 2;
`endif

  typedef struct {
    int edge_n;
    int ch;
    int kind;
  } ev_t;

  ev_t exp_q[$];
  int  cyc;
  int  checks;
  int  errors;
  int  p_ch0;

  debounce_bank #(
    .CHANNELS      (4),
    .DELAY_COUNTS  (Delay),
    .INVERT        (4'b1000),
    .HOLD_COUNTS   (40),
    .REPEAT_COUNTS (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .button   (button),
`ifdef DEBOUNCE_HOLD_EN
    .held     (held),
`endif
    .level    (level),
    .pressed  (pressed),
    .released (released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int k);
    if (k == 0) return "pressed";
    if (k == 1) return "released";
    return "held";
  endfunction

  task automatic push_ev(input int e, input int ch, input int kind);
    ev_t ev;
    ev.edge_n = e;
    ev.ch     = ch;
    ev.kind   = kind;
    exp_q.push_back(ev);
  endtask

  // Every observed or expected pulse is one comparison; held is tracked on channel 0 only.
  always @(negedge clk) begin : mon
    logic obs;
    int   idx;
    if (rst_n === 1'b1) begin
      for (int ch = 0; ch < 4; ch++) begin
        for (int k = 0; k < NKinds; k++) begin
          if (k == 0) obs = pressed[ch];
          else if (k == 1) obs = released[ch];
`ifdef DEBOUNCE_HOLD_EN
          else obs = (ch == 0) ? held[ch] : 1'b0;
`else
          else obs = 1'b0;
`endif
          idx = -1;
          foreach (exp_q[j]) begin
            if (exp_q[j].edge_n == cyc && exp_q[j].ch == ch && exp_q[j].kind == k) idx = j;
          end
          if (obs !== 1'b0 || idx >= 0) begin
            checks++;
            if (obs !== (idx >= 0)) begin
              errors++;
              $display("FAIL pulse_%s ch%0d edge %0d: observed %b expected %b",
                       kind_name(k), ch, cyc, obs, (idx >= 0));
            end
            if (idx >= 0) exp_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    button = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (level !== 4'b0000) begin
      errors++;
      $display("FAIL reset_level: got %b want 0000", level);
    end
    checks++;
    if (pressed !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pressed: got %b want 0000", pressed);
    end
    checks++;
    if (released !== 4'b0000) begin
      errors++;
      $display("FAIL reset_released: got %b want 0000", released);
    end
    // ch3 is inverted, so a low raw input is a held button across reset release.
    push_ev(cyc + Lat, 3, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_inversion();
    repeat (Lat + 2) @(negedge clk);
    checks++;
    if (level !== 4'b1000) begin
      errors++;
      $display("FAIL inversion_level: got %b want 1000", level);
    end
  endtask

  task automatic test_clean_press();
    button[0] = 1'b1;
    push_ev(cyc + Lat, 0, 0);
    repeat (Lat - 1) @(negedge clk);
    checks++;
    if (level[0] !== 1'b0) begin
      errors++;
      $display("FAIL press_early_level: got %b want 0", level[0]);
    end
    @(negedge clk);
    checks++;
    if (level[0] !== 1'b1) begin
      errors++;
      $display("FAIL press_level: got %b want 1", level[0]);
    end
    @(negedge clk);
    checks++;
    if (pressed[0] !== 1'b0) begin
      errors++;
      $display("FAIL press_width: pressed[0] got %b want 0 one cycle later", pressed[0]);
    end
    button[0] = 1'b0;
    push_ev(cyc + Lat, 0, 1);
    repeat (Lat + 2) @(negedge clk);
    checks++;
    if (level !== 4'b1000) begin
      errors++;
      $display("FAIL release_level: got %b want 1000", level);
    end
  endtask

  task automatic test_bounce();
    int   iv[6];
    logic v;
    iv = '{3, 5, 2, 3, 5, 2};
    v  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      button[1] = v;
      repeat (iv[i]) @(negedge clk);
      v = ~v;
    end
    button[1] = 1'b1;
    push_ev(cyc + Lat, 1, 0);
    repeat (Lat + 2) @(negedge clk);
    checks++;
    if (level !== 4'b1010) begin
      errors++;
      $display("FAIL bounce_level: got %b want 1010", level);
    end
  endtask

  task automatic test_glitch();
    button[2] = 1'b1;
    repeat (Delay) @(negedge clk);
    button[2] = 1'b0;
    repeat (Lat + 4) @(negedge clk);
    checks++;
    if (level[2] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level: got %b want 0", level[2]);
    end
  endtask

  // Shortest high period that is still accepted: Delay+2 sampling edges.
  task automatic test_min_width();
    button[2] = 1'b1;
    push_ev(cyc + Lat, 2, 0);
    repeat (Delay + 2) @(negedge clk);
    button[2] = 1'b0;
    push_ev(cyc + Lat, 2, 1);
    repeat (Lat + 2) @(negedge clk);
    checks++;
    if (level !== 4'b1010) begin
      errors++;
      $display("FAIL min_width_level: got %b want 1010", level);
    end
  endtask

  task automatic test_reset_mid();
    button[0] = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_level: got %b want 0000", level);
    end
    checks++;
    if (pressed !== 4'b0000 || released !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_pulses: got %b/%b want 0000/0000", pressed, released);
    end
    repeat (3) @(negedge clk);
    p_ch0 = cyc + Lat;
    push_ev(p_ch0, 0, 0);
    push_ev(p_ch0, 1, 0);
    push_ev(p_ch0, 3, 0);
`ifdef DEBOUNCE_HOLD_EN
    push_ev(p_ch0 + 40, 0, 2);
    push_ev(p_ch0 + 56, 0, 2);
    push_ev(p_ch0 + 72, 0, 2);
`endif
    rst_n = 1'b1;
    repeat (Lat - 1) @(negedge clk);
    checks++;
    if (level !== 4'b0000) begin
      errors++;
      $display("FAIL restart_early_level: got %b want 0000", level);
    end
    @(negedge clk);
    checks++;
    if (level !== 4'b1011) begin
      errors++;
      $display("FAIL restart_level: got %b want 1011", level);
    end
  endtask

  // Release lands exactly on what would be the fourth held edge.
  task automatic test_hold_release();
    while (cyc < p_ch0 + 76) @(negedge clk);
    button[0] = 1'b0;
    push_ev(cyc + Lat, 0, 1);
    repeat (40) @(negedge clk);
    checks++;
    if (level !== 4'b1010) begin
      errors++;
      $display("FAIL hold_release_level: got %b want 1010", level);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    p_ch0  = 0;
    test_reset();
    test_inversion();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_min_width();
    test_reset_mid();
    test_hold_release();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
